// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM state encoding,
// port-select constants and access-counter width.
// Used by: mem_port_arbiter (top), rr_pick2 (picker).
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  // Port identifiers, also the encoding of the datapath mux select.
  localparam logic PORT_IF = 1'b0;  // instruction fetch, read-only
  localparam logic PORT_DM = 1'b1;  // data access, read/write

  // Counter wide enough for the largest legal latency (255).
  localparam int CNT_W = 8;

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Purpose: combinational 2-way round-robin picker.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when the pick is consumed.
// Ports: req0_i/req1_i requests, last_gnt_i previous winner,
//        gnt_valid_o any request present, gnt_id_o winning port.
module rr_pick2
  import mem_port_arbiter_pkg::*;
(
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_gnt_i,
  output logic gnt_valid_o,
  output logic gnt_id_o
);

  assign gnt_valid_o = req0_i | req1_i;

  // On a conflict the port that did not win last time goes next;
  // otherwise the lone requester wins.
  always_comb begin
    gnt_id_o = PORT_IF;
    if (req0_i && req1_i) begin
      gnt_id_o = ~last_gnt_i;
    end else if (req1_i) begin
      gnt_id_o = PORT_DM;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Purpose: shares one single-port fixed-latency memory between a fetch port (0)
//          and a data port (1) with round-robin arbitration.
// Latency: request in IDLE cycle N -> ACCESS N+1..N+LAT -> ack pulse in N+LAT+1.
// Backpressure: level request held until the one-cycle ack; no grant is made
//               outside IDLE, so losers simply wait.
// Ports: req/addr per port (+we/wdata on port 1), ack pulses, registered read
//        data, mux select, memory enable/we/addr/wdata, memory read data, busy.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LAT    = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req0_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic              req1_i,
  input  logic              we1_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] wdata1_i,
  output logic              ack0_o,
  output logic              ack1_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              sel_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              busy_o
);

  state_e             state_q;
  logic               last_gnt_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               sel_q;
  logic               ack0_q;
  logic               ack1_q;
  logic               en_q;
  logic               we_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [DATA_W-1:0]  rdata_q;

  logic gnt_valid;
  logic gnt_id;

  rr_pick2 u_pick (
    .req0_i      (req0_i),
    .req1_i      (req1_i),
    .last_gnt_i  (last_gnt_q),
    .gnt_valid_o (gnt_valid),
    .gnt_id_o    (gnt_id)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      // last_gnt starts at port 1 so port 0 wins the first conflict.
      state_q    <= ST_IDLE;
      last_gnt_q <= PORT_DM;
      cnt_q      <= '0;
      sel_q      <= PORT_IF;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      en_q       <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (gnt_valid) begin
            state_q    <= ST_ACCESS;
            last_gnt_q <= gnt_id;
            sel_q      <= gnt_id;
            en_q       <= 1'b1;
            cnt_q      <= CNT_W'(LAT - 1);
            if (gnt_id == PORT_DM) begin
              addr_q  <= addr1_i;
              we_q    <= we1_i;
              wdata_q <= wdata1_i;
            end else begin
              // Fetch port is read-only; its write enable is forced low.
              addr_q <= addr0_i;
              we_q   <= 1'b0;
            end
          end
        end
        ST_ACCESS: begin
          if (cnt_q == '0) begin
            // Last access cycle: memory data is valid now.
            if (!we_q) begin
              rdata_q <= mem_rdata_i;
            end
            en_q    <= 1'b0;
            we_q    <= 1'b0;
            ack0_q  <= (sel_q == PORT_IF);
            ack1_q  <= (sel_q == PORT_DM);
            state_q <= ST_RESP;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ST_RESP: begin
          // No grant here, so a still-high request from the acked port
          // is only reconsidered in IDLE next cycle.
          ack0_q  <= 1'b0;
          ack1_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign ack0_o      = ack0_q;
  assign ack1_o      = ack1_q;
  assign rdata_o     = rdata_q;
  assign sel_o       = sel_q;
  assign mem_en_o    = en_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (LAT=2 and LAT=1) share one
// stimulus stream; each is compared every cycle against a transaction-level
// model, plus directed checks of latency, grant order and async reset.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LATK [2] = '{2, 1};

  logic          clk_i;
  logic          rst_i;
  logic          req0_i;
  logic [AW-1:0] addr0_i;
  logic          req1_i;
  logic          we1_i;
  logic [AW-1:0] addr1_i;
  logic [DW-1:0] wdata1_i;
  logic [DW-1:0] mem_rdata_i;

  logic [1:0]    ack0_w;
  logic [1:0]    ack1_w;
  logic [1:0]    sel_w;
  logic [1:0]    en_w;
  logic [1:0]    we_w;
  logic [1:0]    busy_w;
  logic [DW-1:0] rdata_w [2];
  logic [AW-1:0] maddr_w [2];
  logic [DW-1:0] mwdata_w [2];

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LAT(2)) u_dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req0_i      (req0_i),
    .addr0_i     (addr0_i),
    .req1_i      (req1_i),
    .we1_i       (we1_i),
    .addr1_i     (addr1_i),
    .wdata1_i    (wdata1_i),
    .ack0_o      (ack0_w[0]),
    .ack1_o      (ack1_w[0]),
    .rdata_o     (rdata_w[0]),
    .sel_o       (sel_w[0]),
    .mem_en_o    (en_w[0]),
    .mem_we_o    (we_w[0]),
    .mem_addr_o  (maddr_w[0]),
    .mem_wdata_o (mwdata_w[0]),
    .mem_rdata_i (mem_rdata_i),
    .busy_o      (busy_w[0])
  );

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LAT(1)) u_dut_lat1 (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req0_i      (req0_i),
    .addr0_i     (addr0_i),
    .req1_i      (req1_i),
    .we1_i       (we1_i),
    .addr1_i     (addr1_i),
    .wdata1_i    (wdata1_i),
    .ack0_o      (ack0_w[1]),
    .ack1_o      (ack1_w[1]),
    .rdata_o     (rdata_w[1]),
    .sel_o       (sel_w[1]),
    .mem_en_o    (en_w[1]),
    .mem_we_o    (we_w[1]),
    .mem_addr_o  (maddr_w[1]),
    .mem_wdata_o (mwdata_w[1]),
    .mem_rdata_i (mem_rdata_i),
    .busy_o      (busy_w[1])
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  // A transaction granted in IDLE cycle n occupies ACCESS cycles n+1..n+LAT
  // and acks in cycle n+LAT+1; the arbiter is idle from n+LAT+2 on.
  int            cyc = 0;
  int            m_n     [2];
  logic          m_port  [2];
  logic          m_we    [2];
  logic          m_last  [2];
  logic          m_sel   [2];
  logic [AW-1:0] m_addr  [2];
  logic [DW-1:0] m_wdata [2];
  logic [DW-1:0] m_rdata [2];

  // Observed acks: port and cycle, per instance.
  int ack_port_q0[$];
  int ack_cyc_q0[$];
  int ack_port_q1[$];
  int ack_cyc_q1[$];

  always @(negedge clk_i) begin
    int   ph;
    int   lat;
    logic acc, rsp, idl, win;
    for (int k = 0; k < 2; k++) begin
      if (!rst_i) begin
        m_n[k]     = -100;
        m_port[k]  = 1'b0;
        m_we[k]    = 1'b0;
        m_last[k]  = 1'b1;
        m_sel[k]   = 1'b0;
        m_addr[k]  = '0;
        m_wdata[k] = '0;
        m_rdata[k] = '0;
        chk($sformatf("rst_out%0d", k),
            {ack0_w[k], ack1_w[k], en_w[k], we_w[k], busy_w[k], sel_w[k]}, 64'd0);
        chk($sformatf("rst_data%0d", k), {rdata_w[k], maddr_w[k]}, 64'd0);
      end else begin
        lat = LATK[k];
        ph  = cyc - m_n[k];
        acc = (ph >= 1) && (ph <= lat);
        rsp = (ph == lat + 1);
        idl = !acc && !rsp;
        chk($sformatf("en%0d", k),    en_w[k],   acc);
        chk($sformatf("we%0d", k),    we_w[k],   acc && m_we[k]);
        chk($sformatf("busy%0d", k),  busy_w[k], !idl);
        chk($sformatf("ack0_%0d", k), ack0_w[k], rsp && (m_port[k] == 1'b0));
        chk($sformatf("ack1_%0d", k), ack1_w[k], rsp && (m_port[k] == 1'b1));
        chk($sformatf("sel%0d", k),   sel_w[k],  m_sel[k]);
        chk($sformatf("addr%0d", k),  maddr_w[k], m_addr[k]);
        chk($sformatf("rdata%0d", k), rdata_w[k], m_rdata[k]);
        if (acc && m_we[k]) chk($sformatf("wdata%0d", k), mwdata_w[k], m_wdata[k]);

        if (acc && ph == lat && !m_we[k]) m_rdata[k] = mem_rdata_i;
        if (idl && (req0_i || req1_i)) begin
          win       = (req0_i && req1_i) ? ~m_last[k] : req1_i;
          m_n[k]    = cyc;
          m_port[k] = win;
          m_sel[k]  = win;
          m_last[k] = win;
          m_addr[k] = win ? addr1_i : addr0_i;
          m_we[k]   = win & we1_i;
          if (win) m_wdata[k] = wdata1_i;
        end
      end
    end
    if (ack0_w[0]) begin ack_port_q0.push_back(0); ack_cyc_q0.push_back(cyc); end
    if (ack1_w[0]) begin ack_port_q0.push_back(1); ack_cyc_q0.push_back(cyc); end
    if (ack0_w[1]) begin ack_port_q1.push_back(0); ack_cyc_q1.push_back(cyc); end
    if (ack1_w[1]) begin ack_port_q1.push_back(1); ack_cyc_q1.push_back(cyc); end
    cyc++;
  end

  // ---------------- stimulus ----------------
  task automatic next_cycle(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic clear_logs();
    ack_port_q0.delete(); ack_cyc_q0.delete();
    ack_port_q1.delete(); ack_cyc_q1.delete();
  endtask

  function automatic int first_or(input int q[$], input int idx);
    return (q.size() > idx) ? q[idx] : -1;
  endfunction

  int t0;

  initial begin
    rst_i = 1'b0; req0_i = 1'b0; addr0_i = '0; req1_i = 1'b0; we1_i = 1'b0;
    addr1_i = '0; wdata1_i = '0; mem_rdata_i = '0;
    next_cycle(3);
    rst_i = 1'b1;

    // Lone read.
    clear_logs();
    mem_rdata_i = 32'hDEAD_BEEF;
    req0_i = 1'b1; addr0_i = 32'h40;
    t0 = cyc;
    next_cycle(1);
    req0_i = 1'b0;
    chk("rd_addr0", maddr_w[0], 32'h40);
    next_cycle(5);
    chk("rd_lat0", first_or(ack_cyc_q0, 0) - t0, 3);
    chk("rd_lat1", first_or(ack_cyc_q1, 0) - t0, 2);
    chk("rd_data0", rdata_w[0], 32'hDEAD_BEEF);
    chk("rd_data1", rdata_w[1], 32'hDEAD_BEEF);

    // Lone write: rdata must be untouched.
    clear_logs();
    mem_rdata_i = 32'h5555_AAAA;
    req1_i = 1'b1; we1_i = 1'b1; addr1_i = 32'h80; wdata1_i = 32'h1234;
    next_cycle(1);
    chk("wr_we0", we_w[0], 1'b1);
    chk("wr_wdata0", mwdata_w[0], 32'h1234);
    req1_i = 1'b0; we1_i = 1'b0;
    next_cycle(5);
    chk("wr_acks0", ack_port_q0.size(), 1);
    chk("wr_acks1", ack_port_q1.size(), 1);
    chk("wr_rdata0", rdata_w[0], 32'hDEAD_BEEF);

    // Address changed mid-access must not leak through.
    req1_i = 1'b1; addr1_i = 32'h80;
    next_cycle(1);
    addr1_i = 32'hFF;
    next_cycle(1);
    chk("hold_addr0", maddr_w[0], 32'h80);
    req1_i = 1'b0;
    next_cycle(5);

    // Continuous conflict: grants alternate starting with port 0.
    clear_logs();
    req0_i = 1'b1; addr0_i = 32'h100; req1_i = 1'b1; addr1_i = 32'h200;
    next_cycle(20);
    req0_i = 1'b0; req1_i = 1'b0;
    next_cycle(6);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rr_order0_%0d", i), first_or(ack_port_q0, i), i % 2);
      chk($sformatf("rr_order1_%0d", i), first_or(ack_port_q1, i), i % 2);
    end
    chk("rr_gap0", first_or(ack_cyc_q0, 1) - first_or(ack_cyc_q0, 0), 4);
    chk("rr_gap1", first_or(ack_cyc_q1, 1) - first_or(ack_cyc_q1, 0), 3);

    // Async reset in the middle of an access.
    clear_logs();
    req1_i = 1'b1; we1_i = 1'b1; addr1_i = 32'h10; wdata1_i = 32'h77;
    next_cycle(1);
    #2 rst_i = 1'b0;
    #1;
    chk("arst_en", en_w, 2'b00);
    chk("arst_busy", busy_w, 2'b00);
    chk("arst_sel", sel_w, 2'b00);
    next_cycle(2);
    chk("arst_noack", ack_port_q0.size() + ack_port_q1.size(), 0);
    rst_i = 1'b1;
    next_cycle(1);
    req1_i = 1'b0; we1_i = 1'b0;
    next_cycle(5);
    chk("reissue_ack0", first_or(ack_port_q0, 0), 1);
    chk("reissue_ack1", first_or(ack_port_q1, 0), 1);
    chk("reissue_cnt", ack_port_q0.size() + ack_port_q1.size(), 2);

    // Randomized traffic; the per-cycle model does the checking.
    for (int i = 0; i < 800; i++) begin
      req0_i      = ($urandom_range(0, 3) != 0);
      req1_i      = ($urandom_range(0, 3) != 0);
      we1_i       = $urandom_range(0, 1);
      addr0_i     = $urandom;
      addr1_i     = $urandom;
      wdata1_i    = $urandom;
      mem_rdata_i = $urandom;
      next_cycle(1);
    end
    req0_i = 1'b0; req1_i = 1'b0;
    next_cycle(6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
